// File: rtl/branch_predictor_btb_if.sv
// Fetch lookup / Execute resolve bundle between the core pipeline and the BTB.
// Pure wiring: no latency, no backpressure.
interface branch_predictor_btb_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] PCF;
  logic              PredictF;
  logic [ADDR_W-1:0] PredTargetF;
  logic              PCWriteE;
  logic              BranchE;
  logic [ADDR_W-1:0] PCE;
  logic              PredictedE;
  logic [ADDR_W-1:0] PredTargetE;
  logic              BranchTakenE;
  logic [ADDR_W-1:0] BranchTargetE;
  logic [1:0]        PCSrcSelect;
  logic              FlushMispredict;
  logic [15:0]       MispredictCount;

  modport master (
    output PCF, PCWriteE, BranchE, PCE, PredictedE, PredTargetE,
           BranchTakenE, BranchTargetE,
    input  PredictF, PredTargetF, PCSrcSelect, FlushMispredict, MispredictCount
  );

  modport slave (
    input  PCF, PCWriteE, BranchE, PCE, PredictedE, PredTargetE,
           BranchTakenE, BranchTargetE,
    output PredictF, PredTargetF, PCSrcSelect, FlushMispredict, MispredictCount
  );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with saturating direction counters and fetch PC-source select.
// Lookup/select combinational (0 cycles), training lands on the next edge; never stalls.
module branch_predictor_btb #(
  parameter int ENTRIES  = 16,
  parameter int ADDR_W   = 32,
  parameter int CNT_W    = 2,
  parameter int INIT_CNT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  branch_predictor_btb_if.slave  btb
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] tgt;
    cnt_t              cnt;
  } entry_t;

  localparam cnt_t CNT_MAX    = {CNT_W{1'b1}};
  localparam cnt_t CNT_WEAK_T = cnt_t'(1) << (CNT_W - 1);
  localparam cnt_t CNT_INIT   = cnt_t'(INIT_CNT);

  localparam logic [1:0] SEL_PC4    = 2'b00;
  localparam logic [1:0] SEL_ALU    = 2'b01;
  localparam logic [1:0] SEL_PRED   = 2'b10;
  localparam logic [1:0] SEL_PC4_E  = 2'b11;

  entry_t      entry_q [ENTRIES];
  logic [15:0] mis_cnt_q;
  logic [15:0] mis_cnt_d;

  // Fetch-side lookup
  logic [IDX_W-1:0] idx_f;
  logic [TAG_W-1:0] tag_f;
  entry_t           entry_f;
  logic             hit_f;

  assign idx_f   = btb.PCF[IDX_W+1:2];
  assign tag_f   = btb.PCF[ADDR_W-1:IDX_W+2];
  assign entry_f = entry_q[idx_f];
  assign hit_f   = entry_f.valid && (entry_f.tag == tag_f);

  assign btb.PredictF    = !reset && hit_f && entry_f.cnt[CNT_W-1];
  assign btb.PredTargetF = entry_f.tgt;

  // Execute-side resolution
  logic [IDX_W-1:0] idx_e;
  logic [TAG_W-1:0] tag_e;
  entry_t           entry_e;
  logic             hit_e;
  logic             dir_miss_taken;
  logic             tgt_miss;
  logic             dir_miss_nt;
  logic             mispredict;

  assign idx_e   = btb.PCE[IDX_W+1:2];
  assign tag_e   = btb.PCE[ADDR_W-1:IDX_W+2];
  assign entry_e = entry_q[idx_e];
  assign hit_e   = entry_e.valid && (entry_e.tag == tag_e);

  assign dir_miss_taken = btb.BranchE && btb.BranchTakenE && !btb.PredictedE;
  assign tgt_miss       = btb.BranchE && btb.BranchTakenE && btb.PredictedE &&
                          (btb.PredTargetE != btb.BranchTargetE);
  assign dir_miss_nt    = btb.BranchE && btb.PredictedE && !btb.BranchTakenE;
  assign mispredict     = dir_miss_taken || tgt_miss || dir_miss_nt;

  logic [1:0] sel;

  always_comb begin
    sel = SEL_PC4;
    if (reset) begin
      sel = SEL_PC4;
    end else if (btb.PCWriteE || dir_miss_taken || tgt_miss) begin
      sel = SEL_ALU;
    end else if (dir_miss_nt) begin
      sel = SEL_PC4_E;
    end else if (btb.PredictF) begin
      sel = SEL_PRED;
    end
  end

  assign btb.PCSrcSelect     = sel;
  assign btb.FlushMispredict = (sel == SEL_ALU) || (sel == SEL_PC4_E);
  assign btb.MispredictCount = mis_cnt_q;

  // Training write: one entry per cycle, a not-taken miss leaves the table alone
  logic   wr_en;
  entry_t wr_entry_d;

  always_comb begin
    wr_en      = 1'b0;
    wr_entry_d = entry_e;
    if (btb.BranchE) begin
      if (hit_e) begin
        wr_en = 1'b1;
        if (btb.BranchTakenE) begin
          wr_entry_d.tgt = btb.BranchTargetE;
          if (entry_e.cnt != CNT_MAX) begin
            wr_entry_d.cnt = entry_e.cnt + cnt_t'(1);
          end
        end else if (entry_e.cnt != '0) begin
          wr_entry_d.cnt = entry_e.cnt - cnt_t'(1);
        end
      end else if (btb.BranchTakenE) begin
        wr_en      = 1'b1;
        wr_entry_d = '{valid: 1'b1, tag: tag_e, tgt: btb.BranchTargetE, cnt: CNT_WEAK_T};
      end
    end
  end

  always_comb begin
    mis_cnt_d = mis_cnt_q;
    if (mispredict && (mis_cnt_q != 16'hFFFF)) begin
      mis_cnt_d = mis_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entry_q[i] <= '{valid: 1'b0, tag: '0, tgt: '0, cnt: CNT_INIT};
      end
      mis_cnt_q <= '0;
    end else begin
      if (wr_en) begin
        entry_q[idx_e] <= wr_entry_d;
      end
      mis_cnt_q <= mis_cnt_d;
    end
  end

  // Word-offset bits never take part in indexing or tagging
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^{btb.PCF[1:0], btb.PCE[1:0]};
endmodule

// File: tb/tb_branch_predictor_btb.sv
module tb_branch_predictor_btb;
  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  branch_predictor_btb_if #(.ADDR_W(32)) btb_bus ();

  branch_predictor_btb #(
    .ENTRIES(16), .ADDR_W(32), .CNT_W(2), .INIT_CNT(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .btb   (btb_bus)
  );

  typedef struct {
    int          id;
    logic        pred;
    logic [31:0] tgt;
    logic [1:0]  sel;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   step_id = 0;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL step%0d %s actual=%0h required=%0h", id, name, act, req);
    end
  endtask

  // Monitor: the DUT presents a fresh combinational response every cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("PCSrcSelect", e.id, 32'(btb_bus.PCSrcSelect), 32'(e.sel));
        chk("FlushMispredict", e.id, 32'(btb_bus.FlushMispredict),
            32'((e.sel == 2'b01) || (e.sel == 2'b11)));
        chk("MispredictCount", e.id, 32'(btb_bus.MispredictCount), 32'(e.cnt));
        chk("PredictF", e.id, 32'(btb_bus.PredictF), 32'(e.pred));
        if (e.pred) chk("PredTargetF", e.id, btb_bus.PredTargetF, e.tgt);
      end
    end
  end

  task automatic step(input logic rst, input logic [31:0] pcf, input logic pcw,
                      input logic br, input logic [31:0] pce, input logic pe,
                      input logic [31:0] pte, input logic tk, input logic [31:0] te,
                      input logic ep, input logic [31:0] et, input logic [1:0] es,
                      input logic [15:0] ec);
    exp_t e;
    @(posedge clk);
    #1;
    reset                 = rst;
    btb_bus.PCF           = pcf;
    btb_bus.PCWriteE      = pcw;
    btb_bus.BranchE       = br;
    btb_bus.PCE           = pce;
    btb_bus.PredictedE    = pe;
    btb_bus.PredTargetE   = pte;
    btb_bus.BranchTakenE  = tk;
    btb_bus.BranchTargetE = te;
    step_id++;
    e.id = step_id; e.pred = ep; e.tgt = et; e.sel = es; e.cnt = ec;
    sb.push_back(e);
  endtask

  task automatic look(input logic rst, input logic [31:0] pcf, input logic ep,
                      input logic [31:0] et, input logic [1:0] es, input logic [15:0] ec);
    step(rst, pcf, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, ep, et, es, ec);
  endtask

  initial begin
    btb_bus.PCF = '0; btb_bus.PCWriteE = 0; btb_bus.BranchE = 0; btb_bus.PCE = '0;
    btb_bus.PredictedE = 0; btb_bus.PredTargetE = '0; btb_bus.BranchTakenE = 0;
    btb_bus.BranchTargetE = '0;

    look(1, 32'h40, 0, 0, 2'b00, 16'd0);
    look(0, 32'h40, 0, 0, 2'b00, 16'd0);
    // cold taken branch at 0x40: redirect, allocate weakly taken
    step(0, 32'h40, 0, 1, 32'h40, 0, 32'h0, 1, 32'h100, 0, 0, 2'b01, 16'd0);
    look(0, 32'h40, 1, 32'h100, 2'b10, 16'd1);
    // correctly predicted taken -> cnt 3
    step(0, 32'h44, 0, 1, 32'h40, 1, 32'h100, 1, 32'h100, 0, 0, 2'b00, 16'd1);
    // two predicted-taken branches resolve not taken: 3->2->1
    step(0, 32'h44, 0, 1, 32'h40, 1, 32'h100, 0, 32'h0, 0, 0, 2'b11, 16'd1);
    step(0, 32'h40, 0, 1, 32'h40, 1, 32'h100, 0, 32'h0, 1, 32'h100, 2'b11, 16'd2);
    look(0, 32'h40, 0, 0, 2'b00, 16'd3);
    // target mispredict: 0x100 predicted, 0x200 resolved; cnt 1->2
    step(0, 32'h80, 0, 1, 32'h40, 1, 32'h100, 1, 32'h200, 0, 0, 2'b01, 16'd3);
    look(0, 32'h40, 1, 32'h200, 2'b10, 16'd4);
    // alias 0x80 evicts 0x40; same-cycle lookup still sees the old entry
    step(0, 32'h40, 0, 1, 32'h80, 0, 32'h0, 1, 32'h300, 1, 32'h200, 2'b01, 16'd4);
    look(0, 32'h40, 0, 0, 2'b00, 16'd5);
    look(0, 32'h80, 1, 32'h300, 2'b10, 16'd5);
    for (int k = 0; k < 4; k++)
      step(0, 32'h44, 0, 1, 32'h80, 1, 32'h300, 1, 32'h300, 0, 0, 2'b00, 16'd5);
    // saturated at 3: one not-taken still predicts taken, second does not
    step(0, 32'h44, 0, 1, 32'h80, 1, 32'h300, 0, 32'h0, 0, 0, 2'b11, 16'd5);
    look(0, 32'h80, 1, 32'h300, 2'b10, 16'd6);
    step(0, 32'h80, 0, 1, 32'h80, 1, 32'h300, 0, 32'h0, 1, 32'h300, 2'b11, 16'd6);
    look(0, 32'h80, 0, 0, 2'b00, 16'd7);
    // decrement floor: 1->0->0, then taken -> 1 (still not taken)
    step(0, 32'h44, 0, 1, 32'h80, 0, 32'h0, 0, 32'h0, 0, 0, 2'b00, 16'd7);
    step(0, 32'h44, 0, 1, 32'h80, 0, 32'h0, 0, 32'h0, 0, 0, 2'b00, 16'd7);
    step(0, 32'h44, 0, 1, 32'h80, 0, 32'h0, 1, 32'h300, 0, 0, 2'b01, 16'd7);
    look(0, 32'h80, 0, 0, 2'b00, 16'd8);
    // not-taken miss must not allocate
    step(0, 32'h48, 0, 1, 32'h44, 0, 32'h0, 0, 32'h500, 0, 0, 2'b00, 16'd8);
    look(0, 32'h44, 0, 0, 2'b00, 16'd8);
    // 0x80 back to cnt 2, then PCWriteE overrides a predicted-taken fetch
    step(0, 32'h44, 0, 1, 32'h80, 0, 32'h0, 1, 32'h300, 0, 0, 2'b01, 16'd8);
    step(0, 32'h80, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 32'h300, 2'b01, 16'd9);
    look(0, 32'h80, 1, 32'h300, 2'b10, 16'd9);
    // reset alongside a mispredicting branch: gated outputs, update and count dropped
    step(1, 32'h80, 0, 1, 32'h40, 0, 32'h0, 1, 32'h100, 0, 0, 2'b00, 16'd9);
    look(0, 32'h80, 0, 0, 2'b00, 16'd0);
    look(0, 32'h40, 0, 0, 2'b00, 16'd0);
    // PCWriteE and BranchE together: select 01, branch still counted
    step(0, 32'h44, 1, 1, 32'h40, 1, 32'h0, 0, 32'h0, 0, 0, 2'b01, 16'd0);
    look(0, 32'h44, 0, 0, 2'b00, 16'd1);

    @(posedge clk);
    #1;
    for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
